// File: rtl/fifo_read_port_pkg.sv
// rtl/fifo_read_port_pkg.sv - shared constants and state encoding for the FIFO read port
package fifo_read_port_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam logic [3:0] CNT_EMPTY = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - main/skid output buffer and its 3-state occupancy FSM
module fifo_out_buf
  import fifo_read_port_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       buf_level,
  output logic             full
);

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             ld_main_rd, ld_main_skid, ld_skid;
  logic             accept;

  assign m_valid   = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign accept    = m_valid & m_ready;
  assign m_data    = main_q;
  assign buf_level = (state_q == ST_TWO) ? 2'd2 : (state_q == ST_ONE) ? 2'd1 : 2'd0;
  // Anything other than EMPTY/ONE blocks popping, so an illegal encoding cannot swallow a word.
  assign full      = (state_q != ST_EMPTY) && (state_q != ST_ONE);

  always_comb begin
    state_d      = state_q;
    ld_main_rd   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (pop) begin
          state_d    = ST_ONE;
          ld_main_rd = 1'b1;
        end
      end
      ST_ONE: begin
        if (pop && accept) begin
          ld_main_rd = 1'b1;
        end else if (pop) begin
          state_d = ST_TWO;
          ld_skid = 1'b1;
        end else if (accept) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (accept) begin
          state_d      = ST_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld_main_rd) main_q <= rd_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= rd_data;
    end
  end

endmodule

// File: rtl/fifo_read_port.sv
// rtl/fifo_read_port.sv - FIFO read-side controller driving a valid/ready output stream
module fifo_read_port
  import fifo_read_port_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_increment,
  output logic             fifo_decrement,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       buf_level
);

  logic fifo_empty;
  logic buf_full;
  logic pop;

  assign fifo_empty = (fifo_count == {CNT_W{1'b1}});
  // The counter treats inc&dec as a plain increment, so a pop yields to a writer push and retries.
  // Reset gating keeps the counter untouched while both sides are held in reset.
  assign pop            = reset & !fifo_empty & !fifo_increment & !buf_full;
  assign fifo_decrement = pop;

  fifo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .pop      (pop),
    .rd_data  (fifo_rd_data),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .buf_level(buf_level),
    .full     (buf_full)
  );

endmodule

// File: tb/tb_fifo_read_port.sv
// tb/tb_fifo_read_port.sv - self-checking bench for fifo_read_port
module tb_fifo_read_port;
  import fifo_read_port_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] fifo_count;
  logic [7:0] fifo_rd_data;
  logic       fifo_increment;
  logic       fifo_decrement;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] buf_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] out_q[$];

  typedef struct {
    logic [3:0] count;
    logic       inc;
    logic [7:0] data;
    logic       exp_dec;
  } vec_t;

  vec_t vecs[8];

  fifo_read_port #(.WIDTH(8), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_count    (fifo_count),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_increment(fifo_increment),
    .fifo_decrement(fifo_decrement),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .buf_level     (buf_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fifo_q.delete();
    out_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One clock of the reference model: the bench acts as FIFO storage plus a scoreboard of
  // words handed to the read port, compared against the DUT before the edge.
  task automatic cycle(input logic inc, input logic rdy, input logic [7:0] wdata);
    logic exp_pop;
    logic acc;
    fifo_increment = inc;
    m_ready        = rdy;
    fifo_count     = (fifo_q.size() == 0) ? CNT_EMPTY : 4'(fifo_q.size() - 1);
    fifo_rd_data   = (fifo_q.size() == 0) ? 8'($urandom) : fifo_q[0];
    #1;
    exp_pop = (fifo_q.size() != 0) && !inc && (out_q.size() < 2);
    check("decrement", 32'(fifo_decrement), 32'(exp_pop));
    check("inc_dec_overlap", 32'(fifo_decrement & fifo_increment), 32'd0);
    check("buf_level", 32'(buf_level), 32'(out_q.size()));
    check("m_valid", 32'(m_valid), 32'(out_q.size() != 0));
    if (out_q.size() != 0) check("m_data", 32'(m_data), 32'(out_q[0]));
    acc = (out_q.size() != 0) && rdy;
    @(posedge clk);
    if (acc) void'(out_q.pop_front());
    if (exp_pop) out_q.push_back(fifo_q.pop_front());
    if (inc) fifo_q.push_back(wdata);
    #1;
  endtask

  initial begin
    logic [7:0] seq;
    int run, best;
    logic inc;

    vecs[0] = '{count: 4'hF, inc: 1'b0, data: 8'hAA, exp_dec: 1'b0};
    vecs[1] = '{count: 4'h0, inc: 1'b0, data: 8'hA5, exp_dec: 1'b1};
    vecs[2] = '{count: 4'h3, inc: 1'b0, data: 8'h3C, exp_dec: 1'b1};
    vecs[3] = '{count: 4'h5, inc: 1'b0, data: 8'h5A, exp_dec: 1'b1};
    vecs[4] = '{count: 4'hE, inc: 1'b0, data: 8'hE1, exp_dec: 1'b1};
    vecs[5] = '{count: 4'h0, inc: 1'b1, data: 8'h77, exp_dec: 1'b0};
    vecs[6] = '{count: 4'hF, inc: 1'b1, data: 8'h99, exp_dec: 1'b0};
    vecs[7] = '{count: 4'h2, inc: 1'b1, data: 8'h12, exp_dec: 1'b0};

    // reset with a non-empty FIFO
    reset = 1'b0; fifo_count = 4'd2; fifo_rd_data = 8'h55; fifo_increment = 1'b0; m_ready = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_dec", 32'(fifo_decrement), 32'd0);
    check("rst_level", 32'(buf_level), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1;

    // single-cycle pop decision table from a fresh EMPTY state
    for (int i = 0; i < 8; i++) begin
      reset = 1'b0;
      fifo_count = vecs[i].count; fifo_increment = vecs[i].inc;
      fifo_rd_data = vecs[i].data; m_ready = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("tbl_dec", 32'(fifo_decrement), 32'(vecs[i].exp_dec));
      @(posedge clk);
      #1;
      check("tbl_valid", 32'(m_valid), 32'(vecs[i].exp_dec));
      check("tbl_level", 32'(buf_level), vecs[i].exp_dec ? 32'd1 : 32'd0);
      check("tbl_data", 32'(m_data), vecs[i].exp_dec ? 32'(vecs[i].data) : 32'd0);
    end

    // backpressure: 4 words, consumer stalled, then drained in order
    do_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00);
    check("bp_level", 32'(buf_level), 32'd2);
    check("bp_data", 32'(m_data), 32'h11);
    check("bp_fifo_left", 32'(fifo_q.size()), 32'd2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00);
    check("bp_drained", 32'(out_q.size() + fifo_q.size()), 32'd0);

    // collision: writer push blocks the pop for exactly that cycle
    do_reset();
    fifo_q = '{8'h61, 8'h62};
    fifo_increment = 1'b1; fifo_count = 4'd1; fifo_rd_data = 8'h61; m_ready = 1'b1;
    #1;
    check("col_dec_blocked", 32'(fifo_decrement), 32'd0);
    cycle(1'b1, 1'b1, 8'h63);
    fifo_increment = 1'b0;
    #1;
    check("col_dec_retry", 32'(fifo_decrement), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);

    // streaming: one word per cycle with m_valid high for 4 consecutive cycles
    do_reset();
    fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run = 0; best = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      if (m_valid) run++; else run = 0;
      if (run > best) best = run;
    end
    check("stream_run", 32'(best), 32'd4);

    // reset while holding two words
    do_reset();
    fifo_q = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    check("two_level", 32'(buf_level), 32'd2);
    fifo_count = 4'd0; fifo_increment = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_level", 32'(buf_level), 32'd0);
    check("mid_rst_dec", 32'(fifo_decrement), 32'd0);
    fifo_q.delete();
    out_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    fifo_count = CNT_EMPTY;
    #1;
    check("post_rst_level", 32'(buf_level), 32'd0);
    check("post_rst_valid", 32'(m_valid), 32'd0);

    // randomized traffic against the scoreboard
    seq = 8'h00;
    for (int i = 0; i < 400; i++) begin
      inc = (fifo_q.size() < 4) && ($urandom_range(0, 2) == 0);
      if (inc) seq++;
      cycle(inc, 1'($urandom_range(0, 3) != 0 || i > 380), seq);
    end
    check("rand_order_tail", 32'(out_q.size() <= 2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
